// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch port.
// Fixed-latency read with valid/ready on both sides and a side load port.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_instr,
  output logic             rsp_err,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [31:0]      load_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      widx;
  logic [IDX_W-1:0] idx;
  logic             bad;
  logic             accept;

  assign widx   = {2'b00, req_addr[31:2]};
  assign idx    = req_addr[IDX_W+1:2];
  assign bad    = (req_addr[1:0] != 2'b00) ||
                  (widx >= 32'(DEPTH_WORDS));
  assign accept = (state == IDLE) && req_valid;

  // State and latency counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: accept, count down latency, wait for handshake
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture word at acceptance; held until the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_instr <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      if (bad) begin
        rsp_instr <= 32'h0;
        rsp_err   <= 1'b1;
      end else begin
        rsp_instr <= mem[idx];
        rsp_err   <= 1'b0;
      end
    end
  end

  // Program load port; contents survive reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: timeline model plus directed fetches.
// Instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_err;
  logic [1:0]  load_en;
  logic [31:0] req_addr  [2];
  logic [31:0] rsp_instr [2];
  logic [7:0]  load_idx  [2];
  logic [31:0] load_data [2];

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_instr(rsp_instr[0]), .rsp_err(rsp_err[0]),
    .load_en(load_en[0]), .load_idx(load_idx[0]),
    .load_data(load_data[0])
  );

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_instr(rsp_instr[1]), .rsp_err(rsp_err[1]),
    .load_en(load_en[1]), .load_idx(load_idx[1]),
    .load_data(load_data[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: one pending fetch per instance, due at an absolute edge
  int          lat      [2] = '{2, 1};
  bit          pend     [2] = '{0, 0};
  int          ready_at [2] = '{0, 0};
  int          acc_at   [2] = '{0, 0};
  int          hs       [2] = '{0, 0};
  logic [31:0] mi       [2] = '{32'h0, 32'h0};
  logic        me       [2] = '{1'b0, 1'b0};
  logic [31:0] mm       [2][256];
  int          cyc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        pend[d] = 1'b0;
        mi[d]   = 32'h0;
        me[d]   = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (pend[d]) begin
          if (cyc >= ready_at[d] && rsp_ready[d]) begin
            pend[d] = 1'b0;
            hs[d]++;
          end
        end else if (req_valid[d]) begin
          pend[d]     = 1'b1;
          ready_at[d] = cyc + lat[d];
          acc_at[d]   = cyc + 1;
          if (req_addr[d][1:0] != 2'b00 ||
              req_addr[d][31:2] >= 30'd256) begin
            mi[d] = 32'h0;
            me[d] = 1'b1;
          end else begin
            mi[d] = mm[d][req_addr[d][9:2]];
            me[d] = 1'b0;
          end
        end
        if (load_en[d]) mm[d][load_idx[d]] = load_data[d];
      end
      cyc++;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check($sformatf("cyc d%0d req_ready", d),
            32'(req_ready[d]), 32'(!pend[d]));
      check($sformatf("cyc d%0d rsp_valid", d),
            32'(rsp_valid[d]),
            32'(pend[d] && cyc >= ready_at[d]));
      check($sformatf("cyc d%0d rsp_instr", d),
            rsp_instr[d], mi[d]);
      check($sformatf("cyc d%0d rsp_err", d),
            32'(rsp_err[d]), 32'(me[d]));
    end
  end

  task automatic load(input logic [7:0] idx,
                      input logic [31:0] data);
    load_en      = 2'b11;
    load_idx[0]  = idx;
    load_idx[1]  = idx;
    load_data[0] = data;
    load_data[1] = data;
    @(posedge clk); #1;
    load_en = 2'b00;
  endtask

  // Hold request until accepted, then wait for the response
  task automatic fetch(input int d,
                       input logic [31:0] addr,
                       input logic [31:0] ei,
                       input logic ee,
                       input string nm);
    int  k;
    bit  rdy;
    req_addr[d]  = addr;
    req_valid[d] = 1'b1;
    k = 0;
    do begin
      rdy = req_ready[d];
      @(posedge clk); #1;
      k++;
    end while (!rdy && k < 10);
    req_valid[d] = 1'b0;
    check({nm, " accepted"}, 32'(rdy), 32'd1);
    k = 0;
    while (!rsp_valid[d] && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, " latency"}, 32'(k), 32'(lat[d] - 1));
    check({nm, " instr"}, rsp_instr[d], ei);
    check({nm, " err"}, 32'(rsp_err[d]), 32'(ee));
  endtask

  initial begin
    int h0;
    int a0;
    req_valid    = 2'b00;
    rsp_ready    = 2'b11;
    load_en      = 2'b00;
    req_addr[0]  = 32'h0;
    req_addr[1]  = 32'h0;
    load_idx[0]  = 8'h0;
    load_idx[1]  = 8'h0;
    load_data[0] = 32'h0;
    load_data[1] = 32'h0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", 32'(req_ready[0]), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst rsp_instr", rsp_instr[0], 32'h0);
    check("rst rsp_err", 32'(rsp_err[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    load(8'd0, 32'h20080005);
    load(8'd1, 32'h20090003);
    load(8'd2, 32'h01095020);
    load(8'd3, 32'h00000000);

    fetch(0, 32'h4, 32'h20090003, 1'b0, "t1");
    @(posedge clk); #1;
    check("t1 req_ready after hs", 32'(req_ready[0]), 32'd1);
    check("t1 rsp_valid after hs", 32'(rsp_valid[0]), 32'd0);

    rsp_ready[0] = 1'b0;
    fetch(0, 32'h8, 32'h01095020, 1'b0, "t2");
    repeat (5) begin
      @(posedge clk); #1;
      check("t2 hold valid", 32'(rsp_valid[0]), 32'd1);
      check("t2 hold instr", rsp_instr[0], 32'h01095020);
      check("t2 hold ready", 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("t2 handshakes", 32'(hs[0]), 32'd2);
    check("t2 released", 32'(rsp_valid[0]), 32'd0);

    fetch(0, 32'h6, 32'h0, 1'b1, "t3 misaligned");
    @(posedge clk); #1;
    fetch(0, 32'h400, 32'h0, 1'b1, "t3 range");
    @(posedge clk); #1;

    load_en[0]   = 1'b1;
    load_idx[0]  = 8'd1;
    load_data[0] = 32'hDEADBEEF;
    fetch(0, 32'h4, 32'h20090003, 1'b0, "t4 collide");
    load_en[0] = 1'b0;
    @(posedge clk); #1;
    fetch(0, 32'h4, 32'hDEADBEEF, 1'b0, "t4 follow");
    @(posedge clk); #1;

    req_addr[0]  = 32'h8;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t5 async valid", 32'(rsp_valid[0]), 32'd0);
    check("t5 async ready", 32'(req_ready[0]), 32'd1);
    check("t5 async instr", rsp_instr[0], 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    h0 = hs[0];
    repeat (10) begin
      @(posedge clk); #1;
      check("t5 no rsp", 32'(rsp_valid[0]), 32'd0);
    end
    fetch(0, 32'h8, 32'h01095020, 1'b0, "t5 idx2");
    @(posedge clk); #1;
    check("t5 one hs", 32'(hs[0] - h0), 32'd1);

    fetch(1, 32'h0, 32'h20080005, 1'b0, "t6 first");
    a0 = acc_at[1];
    fetch(1, 32'h4, 32'h20090003, 1'b0, "t6 second");
    check("t6 spacing", 32'(acc_at[1] - a0), 32'd2);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
